mem_access_stage: RTL and testbench

MEM stage of the 5-stage pipelined MIPS core. It sits between the EX/MEM register and the MEM/WB register. It runs load/store accesses on a req/ack data-memory bus and formats load data (byte/half/word, signed/unsigned). It stalls the pipeline while a bus access is outstanding and hands RegDst/ALUResult/RDMem/cRegWrite/cMemtoReg to the MEM/WB register.

---
 rtl/mem_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
// Runs one load/store at a time on a req/ack data-memory bus, formats load
// data (byte/half/word, signed/unsigned), stalls upstream stages while the
// access is outstanding and passes writeback controls to MEM/WB.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   in_*                EX/MEM register contents
//   mem_req/we/addr/    registered data-memory bus request
//   mem_wdata/mem_be
//   mem_rdata, mem_ack  bus response
//   stall               freeze PC, IF/ID, ID/EX, EX/MEM (MEM/WB IRWr = ~stall)
//   out_*               to MEM/WB register
//   exc_misalign        misaligned access flag (combinational)
//   bus_err             bus timeout flag, valid in the DONE cycle
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_WD,
  input  logic [4:0]  in_RegDst,
  input  logic        in_cRegWrite,
  input  logic        in_cMemtoReg,
  input  logic        in_cMemRead,
  input  logic        in_cMemWrite,
  input  logic [1:0]  in_MemSize,
  input  logic        in_LoadSigned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [4:0]  out_RegDst,
  output logic [31:0] out_ALUResult,
  output logic [31:0] out_RDMem,
  output logic        out_cRegWrite,
  output logic        out_cMemtoReg,
  output logic        exc_misalign,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic          access, is_wr, misalign, start;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdmem_q;
  // Load shape captured at request time so formatting does not rely on
  // EX/MEM holding still while the bus is busy.
  logic          ld_q, sgn_q;
  logic [1:0]    lane_q, size_q;

  assign access   = in_valid & (in_cMemRead | in_cMemWrite);
  assign is_wr    = in_cMemWrite;  // read+write together counts as a write
  always_comb begin
    case (in_MemSize)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = in_ALUResult[0];
      default: misalign = |in_ALUResult[1:0];  // 11 behaves as word
    endcase
  end
  assign start = (state_q == IDLE) & access & ~misalign;

  // Store lane placement, little-endian lanes.
  always_comb begin
    case (in_MemSize)
      2'b00: begin
        be_d    = 4'b0001 << in_ALUResult[1:0];
        wdata_d = {4{in_WD[7:0]}};
      end
      2'b01: begin
        be_d    = in_ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{in_WD[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = in_WD;
      end
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] lane,
                                           input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   fmt_load = {{24{sgn & b[7]}}, b};
      2'b01:   fmt_load = {{16{sgn & h[15]}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (mem_ack || cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    stall         = start | (state_q == BUSY);
    exc_misalign  = (state_q == IDLE) & access & misalign;
    out_RDMem     = (state_q == DONE) ? rdmem_q : 32'h0;
    out_cRegWrite = in_cRegWrite & in_valid & ~exc_misalign
                  & ~((state_q == DONE) & bus_err);
    out_RegDst    = in_RegDst;
    out_ALUResult = in_ALUResult;
    out_cMemtoReg = in_cMemtoReg;
  end

  // Bus and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
      rdmem_q   <= 32'h0;
      cnt_q     <= '0;
      bus_err   <= 1'b0;
      ld_q      <= 1'b0;
      sgn_q     <= 1'b0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mem_req   <= 1'b1;
          mem_we    <= is_wr;
          mem_addr  <= {in_ALUResult[31:2], 2'b00};
          mem_wdata <= wdata_d;
          mem_be    <= be_d;
          cnt_q     <= '0;
          ld_q      <= ~is_wr;
          sgn_q     <= in_LoadSigned;
          lane_q    <= in_ALUResult[1:0];
          size_q    <= in_MemSize;
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdmem_q <= ld_q ? fmt_load(mem_rdata, lane_q, size_q, sgn_q) : 32'h0;
          end else if (cnt_q == CNT_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdmem_q <= 32'h0;
            bus_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int TO = 16;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_cRegWrite = 1'b0, in_cMemtoReg = 1'b0;
  logic        in_cMemRead = 1'b0, in_cMemWrite = 1'b0, in_LoadSigned = 1'b0;
  logic [31:0] in_ALUResult = '0, in_WD = '0, mem_rdata = '0;
  logic [4:0]  in_RegDst = '0;
  logic [1:0]  in_MemSize = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, stall, out_cRegWrite, out_cMemtoReg, exc_misalign, bus_err;
  logic [31:0] mem_addr, mem_wdata, out_ALUResult, out_RDMem;
  logic [3:0]  mem_be;
  logic [4:0]  out_RegDst;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ALUResult(in_ALUResult), .in_WD(in_WD),
    .in_RegDst(in_RegDst), .in_cRegWrite(in_cRegWrite), .in_cMemtoReg(in_cMemtoReg),
    .in_cMemRead(in_cMemRead), .in_cMemWrite(in_cMemWrite), .in_MemSize(in_MemSize),
    .in_LoadSigned(in_LoadSigned), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .out_RegDst(out_RegDst), .out_ALUResult(out_ALUResult), .out_RDMem(out_RDMem),
    .out_cRegWrite(out_cRegWrite), .out_cMemtoReg(out_cMemtoReg), .exc_misalign(exc_misalign),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr; logic [1:0] sz; logic sg;
    logic [31:0] addr, wd, rdata; logic rw; int ack_at;  // ack_at 0: never ack
    logic [3:0] be; logic [31:0] wdata, rdm; logic err;
  } vec_t;
  typedef struct { logic [31:0] rdm; logic rw; logic err; } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 0; in_cMemRead = 0; in_cMemWrite = 0; in_cRegWrite = 0; mem_ack = 0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    int k, stalls, busy_exp;
    bit done;
    @(posedge clk); #1;
    in_valid = 1; in_cMemRead = v.rd; in_cMemWrite = v.wr; in_MemSize = v.sz;
    in_LoadSigned = v.sg; in_ALUResult = v.addr; in_WD = v.wd; in_RegDst = 5'd9;
    in_cRegWrite = v.rw; in_cMemtoReg = v.rd; mem_ack = 0; mem_rdata = v.rdata;
    e.rdm = v.rdm; e.rw = v.rw & ~v.err; e.err = v.err;
    sb.push_back(e);
    @(negedge clk);
    chk({nm, " stall_idle"}, 32'(stall), 1);
    chk({nm, " req_idle"}, 32'(mem_req), 0);
    stalls = 1; k = 0; done = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      if (stall) begin
        k++; stalls++;
        if (k == 1) begin
          chk({nm, " req"}, 32'(mem_req), 1);
          chk({nm, " we"}, 32'(mem_we), 32'(v.wr));
          chk({nm, " addr"}, mem_addr, {v.addr[31:2], 2'b00});
          chk({nm, " be"}, 32'(mem_be), 32'(v.be));
          chk({nm, " wdata"}, mem_wdata, v.wdata);
        end
        mem_ack = (k == v.ack_at);
      end else begin
        done = 1;
        mem_ack = 0;
        if (sb.size() == 0) chk({nm, " sb_empty"}, 1, 0);
        else begin
          e = sb.pop_front();
          if (!e.err) chk({nm, " rdmem"}, out_RDMem, e.rdm);
          chk({nm, " regwr"}, 32'(out_cRegWrite), 32'(e.rw));
          chk({nm, " bus_err"}, 32'(bus_err), 32'(e.err));
          chk({nm, " req_done"}, 32'(mem_req), 0);
          chk({nm, " alu_pass"}, out_ALUResult, v.addr);
        end
      end
    end
    if (!done) chk({nm, " done_timeout"}, 0, 1);
    busy_exp = (v.ack_at == 0) ? TO : v.ack_at;
    chk({nm, " stall_cycles"}, 32'(stalls), 32'(busy_exp + 1));
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk({nm, " stall_after"}, 32'(stall), 0);
    chk({nm, " err_after"}, 32'(bus_err), 0);
    chk({nm, " rdmem_after"}, out_RDMem, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rd   wr   sz     sg   addr         wd            rdata         rw  ack be       wdata         rdm           err
    vecs[0] = '{1'b0,1'b1,2'b10,1'b0,32'h100,32'hDEADBEEF,32'h0,       1'b0,2, 4'b1111,32'hDEADBEEF,32'h0,       1'b0};
    vecs[1] = '{1'b1,1'b0,2'b00,1'b1,32'h203,32'h0,       32'h80112233,1'b1,1, 4'b1000,32'h0,       32'hFFFFFF80,1'b0};
    vecs[2] = '{1'b1,1'b0,2'b00,1'b0,32'h203,32'h0,       32'h80112233,1'b1,1, 4'b1000,32'h0,       32'h00000080,1'b0};
    vecs[3] = '{1'b0,1'b1,2'b01,1'b0,32'h402,32'h0000ABCD,32'h0,       1'b0,1, 4'b1100,32'hABCDABCD,32'h0,       1'b0};
    vecs[4] = '{1'b1,1'b0,2'b01,1'b1,32'h202,32'h0,       32'h80017FFF,1'b1,3, 4'b1100,32'h0,       32'hFFFF8001,1'b0};
    vecs[5] = '{1'b1,1'b0,2'b01,1'b0,32'h200,32'h0,       32'h1234F00D,1'b1,1, 4'b0011,32'h0,       32'h0000F00D,1'b0};
    vecs[6] = '{1'b1,1'b0,2'b10,1'b1,32'h30C,32'h0,       32'hCAFEF00D,1'b1,2, 4'b1111,32'h0,       32'hCAFEF00D,1'b0};
    vecs[7] = '{1'b0,1'b1,2'b00,1'b0,32'h501,32'h000000A5,32'h0,       1'b0,1, 4'b0010,32'hA5A5A5A5,32'h0,       1'b0};
    vecs[8] = '{1'b1,1'b0,2'b10,1'b0,32'h600,32'h0,       32'h0,       1'b1,0, 4'b1111,32'h0,       32'h0,       1'b1};
    vecs[9] = '{1'b1,1'b1,2'b10,1'b0,32'h700,32'h11223344,32'h55667788,1'b0,1, 4'b1111,32'h11223344,32'h0,       1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req", 32'(mem_req), 0);
    chk("rst we", 32'(mem_we), 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst be", 32'(mem_be), 0);
    chk("rst bus_err", 32'(bus_err), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst rdmem", out_RDMem, 0);
    @(posedge clk); #1 rst = 1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Misaligned accesses: no bus cycle, no stall, writeback suppressed
    @(posedge clk); #1;
    in_valid = 1; in_cMemRead = 1; in_cMemWrite = 0; in_MemSize = 2'b10;
    in_ALUResult = 32'h101; in_cRegWrite = 1;
    @(negedge clk);
    chk("mis_w exc", 32'(exc_misalign), 1);
    chk("mis_w stall", 32'(stall), 0);
    chk("mis_w regwr", 32'(out_cRegWrite), 0);
    @(posedge clk); #1 in_MemSize = 2'b01; in_ALUResult = 32'h403;
    @(negedge clk);
    chk("mis_w req", 32'(mem_req), 0);
    chk("mis_h exc", 32'(exc_misalign), 1);
    chk("mis_h stall", 32'(stall), 0);
    @(posedge clk); #1 in_MemSize = 2'b11; in_ALUResult = 32'h102;
    @(negedge clk);
    chk("mis_r exc", 32'(exc_misalign), 1);
    @(posedge clk); #1 in_MemSize = 2'b01; in_ALUResult = 32'h402;
    @(negedge clk);
    chk("al_h exc", 32'(exc_misalign), 0);
    chk("al_h stall", 32'(stall), 1);
    #1 in_valid = 0;  // withdraw before the edge: no request starts
    @(negedge clk);
    chk("mis req_after", 32'(mem_req), 0);
    drive_idle();

    // Reset in the 3rd BUSY cycle, late ack afterwards
    @(posedge clk); #1;
    in_valid = 1; in_cMemRead = 1; in_cMemWrite = 0; in_MemSize = 2'b10;
    in_ALUResult = 32'h800; in_cRegWrite = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rstb req_busy", 32'(mem_req), 1);
    rst = 0;
    @(posedge clk); #1;
    rst = 1; in_valid = 0; mem_ack = 1;
    @(negedge clk);
    chk("rstb req", 32'(mem_req), 0);
    chk("rstb stall", 32'(stall), 0);
    chk("rstb rdmem", out_RDMem, 0);
    @(negedge clk);
    chk("rstb late_req", 32'(mem_req), 0);
    chk("rstb late_rdmem", out_RDMem, 0);
    chk("rstb late_stall", 32'(stall), 0);
    mem_ack = 0;
    run_vec(vecs[2], "post_rst");

    if (sb.size() != 0) chk("sb leftover", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
